// File: rtl/program_counter.sv
// program_counter: registered instruction address AR (clk, sync reset, incPC, loadFromI, I in; AR out), priority reset > load > increment > hold
module program_counter #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] AR,
  input  logic                  incPC,
  input  logic                  loadFromI,
  input  logic [ADDR_WIDTH-1:0] I
);
  logic [ADDR_WIDTH-1:0] ar_q, ar_d;
  always_comb ar_d = reset ? RESET_VALUE : loadFromI ? I : incPC ? ar_q + ADDR_WIDTH'(1) : ar_q;
  always_ff @(posedge clk) ar_q <= ar_d;
  assign AR = ar_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vectors with hand-computed AR values
module tb_program_counter;
  logic clk = 1'b0;
  logic reset, incPC, loadFromI;
  logic [15:0] I, AR;
  int vectors = 0;
  int miscompares = 0;
  program_counter dut (
    .clk(clk),
    .reset(reset),
    .AR(AR),
    .incPC(incPC),
    .loadFromI(loadFromI),
    .I(I)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: AR=%h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic inc, input logic ld, input logic [15:0] i, input logic [15:0] exp);
    reset = r;
    incPC = inc;
    loadFromI = ld;
    I = i;
    @(posedge clk);
    #1 chk(tag, AR, exp);
  endtask
  initial begin
    step("reset", 1, 0, 0, 16'h0000, 16'h0000);
    step("hold0a", 0, 0, 0, 16'h0000, 16'h0000);
    step("hold0b", 0, 0, 0, 16'h0000, 16'h0000);
    step("inc1", 0, 1, 0, 16'h0000, 16'h0001);
    step("inc2", 0, 1, 0, 16'h0000, 16'h0002);
    step("inc3", 0, 1, 0, 16'h0000, 16'h0003);
    step("hold3a", 0, 0, 0, 16'h0000, 16'h0003);
    step("hold3b", 0, 0, 0, 16'h0000, 16'h0003);
    step("load4", 0, 0, 1, 16'h0004, 16'h0004);
    step("load4_held", 0, 0, 1, 16'h0004, 16'h0004);
    step("track1234", 0, 0, 1, 16'h1234, 16'h1234);
    step("trackabcd", 0, 0, 1, 16'habcd, 16'habcd);
    step("load10", 0, 0, 1, 16'h000a, 16'h000a);
    step("prio_load", 0, 1, 1, 16'h0020, 16'h0020);
    step("prio_reset", 1, 1, 1, 16'h0055, 16'h0000);
    step("inc_after_rst", 0, 1, 0, 16'h0000, 16'h0001);
    step("reset_mid_inc", 1, 1, 0, 16'h0000, 16'h0000);
    step("loadffff", 0, 0, 1, 16'hffff, 16'hffff);
    step("wrap0", 0, 1, 0, 16'h1111, 16'h0000);
    step("wrap1", 0, 1, 0, 16'h2222, 16'h0001);
    step("load_base", 0, 0, 1, 16'h0777, 16'h0777);
    for (int k = 0; k < 10; k++)
      step("isolate", 0, 0, 0, 16'($urandom), 16'h0777);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
